// File: rtl/instruction_queue_pkg.sv
// Shared processor constants used by the fetch/decode front end.
package instruction_queue_pkg;

  // Native instruction word width of the processor.
  localparam int INSTR_W = 16;

  // Pointer width needed to index a buffer of the given depth (never below 1 bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instruction_queue.sv
// In-order instruction holding buffer between fetch and decode.
// Fetch pushes with load/ins_ready, decode pops with out_valid/take.
// A flush drops every buffered word; reset also clears the storage array.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = 4,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ins,
  input  logic             load,
  output logic             ins_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             take,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake flags come from the registered count only, so there is no
  // combinational path from load/take to ins_ready/out_valid.
  assign w_full    = (r_count == FULL_COUNT);
  assign w_empty   = (r_count == '0);
  assign ins_ready = !w_full;
  assign out_valid = !w_empty;

  // A load while full and a take while empty are simply ignored.
  assign w_push = load && !w_full;
  assign w_pop  = take && !w_empty;

  // Storage write port; reset wipes every entry, flush leaves contents alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is reset explicitly because zeroed storage is part of
      // the reset contract; a plain data RAM would normally skip this.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !flush) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so read and write in one cycle never race.
      r_mem[r_wr_ptr] <= ins;
    end
  end

  // Pointer and occupancy tracking; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Oldest word is a mux of registered state, forced to zero when empty.
  assign out   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios plus a long
// randomized run, all compared every cycle against a queue-based model.
module tb_instruction_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] ins = '0;
  logic             load = 1'b0;
  logic             ins_ready;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             take = 1'b0;
  logic [PTR_W:0]   count;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  logic [WIDTH-1:0] model_q[$];

  instruction_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .ins      (ins),
    .load     (load),
    .ins_ready(ins_ready),
    .flush    (flush),
    .out      (out),
    .out_valid(out_valid),
    .take     (take),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_total++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: a plain FIFO of words updated from the sampled inputs.
  always @(posedge clk) begin
    bit push_ok;
    bit pop_ok;
    if (reset || flush) begin
      model_q.delete();
    end else begin
      push_ok = load && (model_q.size() < DEPTH);
      pop_ok  = take && (model_q.size() > 0);
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(ins);
    end
  end

  // Compare all outputs against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count",     32'(count),     32'(model_q.size()));
      check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      check("ins_ready", 32'(ins_ready), 32'(model_q.size() != DEPTH));
      check("out",       32'(out),       (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
    end
  end

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic drive(input bit r, input bit f, input bit l, input bit t,
                       input logic [WIDTH-1:0] d);
    reset = r;
    flush = f;
    load  = l;
    take  = t;
    ins   = d;
    @(negedge clk);
  endtask

  task automatic expect_outs(input string tag, input logic [WIDTH-1:0] e_out,
                             input bit e_valid, input bit e_ready, input int e_count);
    check({tag, "_out"},   32'(out),       32'(e_out));
    check({tag, "_valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, "_ready"}, 32'(ins_ready), 32'(e_ready));
    check({tag, "_count"}, 32'(count),     32'(e_count));
  endtask

  initial begin
    @(negedge clk);
    drive(1, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    chk_en = 1'b1;

    // Reset then idle.
    expect_outs("rst", '0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, '0);
      expect_outs("idle", '0, 0, 1, 0);
    end

    // Fill to DEPTH, first word visible one cycle after its push.
    drive(0, 0, 1, 0, 16'h1111);
    expect_outs("push1", 16'h1111, 1, 1, 1);
    drive(0, 0, 1, 0, 16'h2222);
    drive(0, 0, 1, 0, 16'h3333);
    drive(0, 0, 1, 0, 16'h4444);
    expect_outs("full", 16'h1111, 1, 0, 4);
    drive(0, 0, 1, 0, 16'h5555);
    expect_outs("load_full", 16'h1111, 1, 0, 4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check("drain_out", 32'(out), 32'(16'h1111 * (i + 1)));
      drive(0, 0, 0, 1, '0);
    end
    expect_outs("drained", '0, 0, 1, 0);
    drive(0, 0, 0, 1, '0);
    expect_outs("take_empty", '0, 0, 1, 0);

    // Wrap-around with simultaneous push/pop at occupancy 1.
    drive(0, 0, 1, 0, 16'hA000);
    for (int i = 0; i < 10; i++) begin
      check("wrap_out",   32'(out),   32'(16'hA000 + i));
      check("wrap_count", 32'(count), 32'd1);
      drive(0, 0, 1, 1, 16'(16'hA001 + i));
    end
    check("wrap_last", 32'(out), 32'h0000_A00A);
    drive(0, 0, 0, 1, '0);

    // Push and pop together while full: only the pop happens.
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 16'(16'hC000 + i));
    expect_outs("full2", 16'hC000, 1, 0, 4);
    drive(0, 0, 1, 1, 16'hC0FF);
    expect_outs("full_pp", 16'hC001, 1, 1, 3);
    drive(0, 0, 1, 1, 16'hC100);
    expect_outs("pp3", 16'hC002, 1, 1, 3);

    // Flush beats concurrent load/take; 0xBEEF must never surface.
    drive(0, 1, 1, 1, 16'hBEEF);
    expect_outs("flush", '0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, '0);
      check("no_beef", 32'(out_valid && out == 16'hBEEF), 32'd0);
    end

    // Reset mid-operation with a concurrent load.
    drive(0, 0, 1, 0, 16'h0101);
    drive(0, 0, 1, 0, 16'h0202);
    check("pre_rst_count", 32'(count), 32'd2);
    drive(1, 0, 1, 0, 16'h7777);
    expect_outs("mid_rst", '0, 0, 1, 0);
    drive(0, 0, 1, 0, 16'h1234);
    expect_outs("post_rst", 16'h1234, 1, 1, 1);
    drive(0, 0, 0, 1, '0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 127) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 55),
            16'($urandom));
    end
    drive(0, 1, 0, 0, '0);
    expect_outs("final_flush", '0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
